// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule FSM states and the lower-case sigma functions.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int ROUNDS  = 64;
  localparam int NWORDS  = BLOCK_W / WORD_W;
  localparam int IDX_W   = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/message_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] through a
// sliding 16-word window, one word per accepted output handshake.
module message_schedule
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  input  logic               data_in_last,
  output logic [WORD_W-1:0]  data_out,
  output logic [IDX_W-1:0]   data_out_idx,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               data_out_last
);

  state_t             state_q;
  logic [WORD_W-1:0]  window_q [NWORDS];
  logic [IDX_W-1:0]   idx_q;
  logic               last_q;

  logic               idx_end;
  logic               out_hs;
  logic               in_hs;
  logic [WORD_W-1:0]  w15_d;

  assign idx_end = (idx_q == IDX_W'(ROUNDS - 1));
  assign out_hs  = (state_q == EXPAND) && data_out_ready;

  // A new block may enter while the final word leaves, so the pipe never bubbles.
  assign data_in_ready = (state_q == IDLE) || (idx_end && data_out_ready);
  assign in_hs         = data_in_valid && data_in_ready;

  assign w15_d = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      for (int i = 0; i < NWORDS; i++) begin
        window_q[i] <= '0;
      end
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (in_hs) begin
      for (int i = 0; i < NWORDS; i++) begin
        window_q[i] <= data_in[BLOCK_W-1-i*WORD_W -: WORD_W];
      end
      idx_q   <= '0;
      last_q  <= data_in_last;
      state_q <= EXPAND;
    end else if (out_hs) begin
      if (idx_end) begin
        state_q <= IDLE;
      end else begin
        for (int i = 0; i < NWORDS - 1; i++) begin
          window_q[i] <= window_q[i+1];
        end
        window_q[NWORDS-1] <= w15_d;
        idx_q              <= idx_q + IDX_W'(1);
      end
    end
  end

  assign data_out       = window_q[0];
  assign data_out_idx   = idx_q;
  assign data_out_valid = (state_q == EXPAND);
  assign data_out_last  = last_q && idx_end && (state_q == EXPAND);

endmodule

// File: tb/tb_message_schedule.sv
// Randomised self-checking bench for message_schedule against a FIPS 180-4 style
// schedule model (W[t] from W[t-2], W[t-7], W[t-15], W[t-16]) and a word scoreboard.
module tb_message_schedule;

  logic         clk = 1'b0;
  logic         nrst;
  logic [511:0] data_in;
  logic         data_in_valid;
  logic         data_in_ready;
  logic         data_in_last;
  logic [31:0]  data_out;
  logic [5:0]   data_out_idx;
  logic         data_out_valid;
  logic         data_out_ready;
  logic         data_out_last;

  always #5 clk = ~clk;

  message_schedule dut (
    .clk            (clk),
    .nrst           (nrst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_in_last   (data_in_last),
    .data_out       (data_out),
    .data_out_idx   (data_out_idx),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last)
  );

  int passed = 0;
  int total  = 0;

  logic [511:0] blk_q[$];
  logic         blk_last_q[$];
  logic [31:0]  exp_w_q[$];
  logic         exp_l_q[$];
  int           exp_idx = 0;
  logic [31:0]  mw [64];
  logic [31:0]  abc_ref [int];
  bit           abc_mode = 1'b0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expand_push(input logic [511:0] blk, input logic last);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) mw[t] = blk[511 - 32*t -: 32];
      else        mw[t] = ss1(mw[t-2]) + mw[t-7] + ss0(mw[t-15]) + mw[t-16];
      exp_w_q.push_back(mw[t]);
      exp_l_q.push_back(last && (t == 63));
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // rmode: 0 ready high, 1 ready toggles, 2 ready random.
  // Queued blocks after the first are offered once the current block reaches hold_idx.
  task automatic run(input int rmode, input int hold_idx, input int stop_idx, input int budget);
    int          cycles = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, exp_ready;
    logic [31:0] pd = '0;
    logic [5:0]  pi = '0;
    while (1) begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = ~data_out_ready;
        default: data_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (blk_q.size() > 0 && (exp_w_q.size() == 0 || exp_idx >= hold_idx)) begin
        data_in_valid = 1'b1;
        data_in       = blk_q[0];
        data_in_last  = blk_last_q[0];
      end else begin
        data_in_valid = 1'b0;
      end
      #1;
      exp_ready = (exp_w_q.size() == 0) || (exp_w_q.size() == 1 && data_out_ready);
      check("out_valid", data_out_valid, exp_w_q.size() != 0);
      check("in_ready", data_in_ready, exp_ready);
      if (exp_w_q.size() > 0) begin
        check("data_out", data_out, exp_w_q[0]);
        check("out_idx", data_out_idx, exp_idx);
        check("out_last", data_out_last, exp_l_q[0]);
        if (abc_mode && abc_ref.exists(exp_idx))
          check("abc_word", data_out, abc_ref[exp_idx]);
        if (pv && !pr) begin
          check("stall_data", data_out, pd);
          check("stall_idx", data_out_idx, pi);
          check("stall_last", data_out_last, pl);
        end
      end
      if (stop_idx >= 0 && exp_w_q.size() > 0 && exp_idx == stop_idx) return;
      pv = data_out_valid; pr = data_out_ready;
      pd = data_out; pi = data_out_idx; pl = data_out_last;
      if (exp_w_q.size() > 0 && data_out_ready) begin
        void'(exp_w_q.pop_front());
        void'(exp_l_q.pop_front());
        exp_idx = (exp_idx + 1) % 64;
      end
      if (data_in_valid && exp_ready) begin
        expand_push(blk_q.pop_front(), blk_last_q.pop_front());
        exp_idx = 0;
      end
      cycles++;
      if (blk_q.size() == 0 && exp_w_q.size() == 0) break;
      if (cycles > budget) begin
        total++;
        $error("FAIL timeout: observed %0d cycles expected at most %0d", cycles, budget);
        break;
      end
    end
    data_in_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] abc_blk;
    nrst           = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_in_last   = 1'b0;
    data_out_ready = 1'b0;
    abc_blk        = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    abc_ref[0]  = 32'h61626380;
    abc_ref[15] = 32'h00000018;
    abc_ref[16] = 32'h61626380;
    abc_ref[17] = 32'h000F0000;

    #3;
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_data", data_out, 32'h0);
    check("rst_idx", data_out_idx, 6'd0);
    check("rst_last", data_out_last, 1'b0);
    check("rst_in_ready", data_in_ready, 1'b1);
    #9 nrst = 1'b1;

    // "abc" block, downstream always ready
    abc_mode = 1'b1;
    blk_q.push_back(abc_blk); blk_last_q.push_back(1'b1);
    run(0, 0, -1, 300);

    // same block with ready toggling every cycle
    blk_q.push_back(abc_blk); blk_last_q.push_back(1'b1);
    run(1, 0, -1, 400);
    abc_mode = 1'b0;

    // three random blocks back to back, input valid held
    blk_q.push_back(rand_block()); blk_last_q.push_back(1'b0);
    blk_q.push_back(rand_block()); blk_last_q.push_back(1'b0);
    blk_q.push_back(rand_block()); blk_last_q.push_back(1'b1);
    run(0, 0, -1, 400);

    // next block offered at idx 10 under random backpressure
    blk_q.push_back(rand_block()); blk_last_q.push_back(1'b0);
    blk_q.push_back(rand_block()); blk_last_q.push_back(1'b1);
    run(2, 10, -1, 1000);

    // reset asserted mid-block at idx 20
    blk_q.push_back(rand_block()); blk_last_q.push_back(1'b1);
    run(0, 0, 20, 300);
    nrst = 1'b0;
    #1;
    check("midrst_valid", data_out_valid, 1'b0);
    check("midrst_data", data_out, 32'h0);
    check("midrst_idx", data_out_idx, 6'd0);
    check("midrst_last", data_out_last, 1'b0);
    check("midrst_in_ready", data_in_ready, 1'b1);
    exp_w_q.delete();
    exp_l_q.delete();
    exp_idx = 0;
    #3 nrst = 1'b1;
    blk_q.push_back(rand_block()); blk_last_q.push_back(1'b1);
    run(2, 0, -1, 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
